// File: rtl/lii_out_arbiter_if.sv
// Bundle of requester-side streams and the shared LII phy output channel.
// The arbiter takes the master modport; the environment takes the slave modport.
interface lii_out_arbiter_if #(
  parameter int NREQ = 4,
  parameter int PW   = 1024
);
  logic [NREQ*PW-1:0] req_tdata;
  logic [NREQ-1:0]    req_tvalid;
  logic [NREQ-1:0]    req_tready;
  logic [NREQ*8-1:0]  req_dst;
  logic [PW-1:0]      lii_out_p0_tdata;
  logic               lii_out_p0_tvalid;
  logic               lii_out_p0_tready;
  logic [7:0]         lii_out_p0_src;
  logic [7:0]         lii_out_p0_dst;

  modport master (
    input  req_tdata, req_tvalid, req_dst, lii_out_p0_tready,
    output req_tready, lii_out_p0_tdata, lii_out_p0_tvalid,
    output lii_out_p0_src, lii_out_p0_dst
  );

  modport slave (
    output req_tdata, req_tvalid, req_dst, lii_out_p0_tready,
    input  req_tready, lii_out_p0_tdata, lii_out_p0_tvalid,
    input  lii_out_p0_src, lii_out_p0_dst
  );
endinterface

// File: rtl/lii_out_arbiter.sv
// Round-robin, burst-holding arbiter sharing one LII output channel between
// NREQ kernel streams; beats are tagged with src/dst and leave through a register.
module lii_out_arbiter #(
  parameter int NREQ     = 4,
  parameter int PW       = 1024,
  parameter int BURST    = 4,
  parameter int SRC_BASE = 0
) (
  input  logic                     aclk,
  input  logic                     arstn,
  lii_out_arbiter_if.master        bus,
  output logic [$clog2(NREQ)-1:0]  grant_idx,
  output logic                     busy
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            out_valid_reg;
  logic [PW-1:0]   out_data_reg;
  logic [7:0]      out_src_reg;
  logic [7:0]      out_dst_reg;

  logic            out_free;
  logic            accept;
  logic            last_beat;
  logic [GW-1:0]   rr_pick;
  logic [GW-1:0]   rr_idx;
  logic            rr_found;
  logic [NREQ-1:0] ready_vec;

  // Ready depends only on registers and phy ready, never on req_tvalid.
  assign out_free  = !out_valid_reg || bus.lii_out_p0_tready;
  assign accept    = (state_reg == GRANT) && out_free && bus.req_tvalid[grant_reg];
  assign last_beat = (cnt_reg == CW'(BURST - 1));

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == GRANT) && out_free && (grant_reg == GW'(gi));
    end
  endgenerate

  assign bus.req_tready = ready_vec;

  // Scan starts just after the last grant, so the released requester ranks last.
  always_comb begin
    rr_pick  = grant_reg;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = GW'((int'(grant_reg) + k) % NREQ);
      if (!rr_found && bus.req_tvalid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (rr_found) begin
          state_next = GRANT;
          grant_next = rr_pick;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (!bus.req_tvalid[grant_reg] || (accept && last_beat)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (accept) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_reg     <= IDLE;
      grant_reg     <= GW'(NREQ - 1);
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_dst_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= bus.req_tdata[int'(grant_reg)*PW +: PW];
        out_src_reg   <= 8'(SRC_BASE + int'(grant_reg));
        out_dst_reg   <= bus.req_dst[int'(grant_reg)*8 +: 8];
      end else if (out_free) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.lii_out_p0_tvalid = out_valid_reg;
  assign bus.lii_out_p0_tdata  = out_data_reg;
  assign bus.lii_out_p0_src    = out_src_reg;
  assign bus.lii_out_p0_dst    = out_dst_reg;
  assign grant_idx             = grant_reg;
  assign busy                  = (state_reg == GRANT);
endmodule

// File: tb/tb_lii_out_arbiter.sv
// Directed bench for lii_out_arbiter: a default instance (BURST=4, SRC_BASE=0)
// and a BURST=1, SRC_BASE=254 instance sharing clock and reset.
module tb_lii_out_arbiter;
  localparam int PW = 1024;

  logic       aclk = 1'b0;
  logic       arstn;
  logic [1:0] grant0, grant1;
  logic       busy0, busy1;
  int         ncomp = 0;
  int         nfail = 0;
  int         beat [4];
  int         t2_v [12];
  int         t2_s [12];
  int         t2_n [12];

  lii_out_arbiter_if #(.NREQ(4), .PW(PW)) bus0 ();
  lii_out_arbiter_if #(.NREQ(4), .PW(PW)) bus1 ();

  lii_out_arbiter #(.NREQ(4), .PW(PW), .BURST(4), .SRC_BASE(0)) dut (
    .aclk(aclk), .arstn(arstn), .bus(bus0), .grant_idx(grant0), .busy(busy0)
  );

  lii_out_arbiter #(.NREQ(4), .PW(PW), .BURST(1), .SRC_BASE(254)) dut1 (
    .aclk(aclk), .arstn(arstn), .bus(bus1), .grant_idx(grant1), .busy(busy1)
  );

  always #5 aclk = ~aclk;

  function automatic logic [PW-1:0] mk(int i, int n);
    logic [PW-1:0] r;
    for (int w = 0; w < PW/32; w++) r[w*32 +: 32] = {8'hA0 + 8'(i), 8'(w), 16'(n)};
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
    $display("check %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkd(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got low word %08h, expected low word %08h", tag, obs[31:0], exp[31:0]);
    end
    $display("check %s: data low word %08h expected %08h", tag, obs[31:0], exp[31:0]);
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) bus0.req_tdata[i*PW +: PW] = mk(i, beat[i]);
  endtask

  // Handshakes are sampled mid-cycle; the requester advances its beat after the edge.
  task automatic tick();
    logic [3:0] hs;
    @(negedge aclk);
    hs = bus0.req_tvalid & bus0.req_tready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) beat[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    bus0.req_tvalid = '0;
    bus0.lii_out_p0_tready = 1'b1;
    for (int i = 0; i < 4; i++) beat[i] = 0;
    drive_data();
    @(negedge aclk);
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    arstn = 1'b0;
    bus0.req_tvalid = '0;
    bus0.lii_out_p0_tready = 1'b1;
    bus0.req_dst = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    bus1.req_tvalid = '0;
    bus1.req_tdata = '0;
    bus1.lii_out_p0_tready = 1'b1;
    bus1.req_dst = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int i = 0; i < 4; i++) beat[i] = 0;
    drive_data();

    // Reset state
    #12;
    chk("rst_tvalid", bus0.lii_out_p0_tvalid, 0);
    chkd("rst_tdata", bus0.lii_out_p0_tdata, '0);
    chk("rst_src", bus0.lii_out_p0_src, 0);
    chk("rst_grant", grant0, 3);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", bus0.req_tready, 0);
    chk("rst_grant1", grant1, 3);
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk);
    #1;

    // Single requester, 3 beats, released on valid drop
    bus0.req_tvalid = 4'b0001;
    tick();
    chk("t1_busy", busy0, 1);
    chk("t1_grant", grant0, 0);
    chk("t1_tvalid_arb", bus0.lii_out_p0_tvalid, 0);
    #2;
    chk("t1_ready", bus0.req_tready, 4'b0001);
    tick();
    chk("t1_b0_valid", bus0.lii_out_p0_tvalid, 1);
    chkd("t1_b0_data", bus0.lii_out_p0_tdata, mk(0, 0));
    chk("t1_b0_src", bus0.lii_out_p0_src, 0);
    chk("t1_b0_dst", bus0.lii_out_p0_dst, 8'hD0);
    tick();
    chkd("t1_b1_data", bus0.lii_out_p0_tdata, mk(0, 1));
    tick();
    bus0.req_tvalid = 4'b0000;
    chkd("t1_b2_data", bus0.lii_out_p0_tdata, mk(0, 2));
    chk("t1_b2_busy", busy0, 1);
    tick();
    chk("t1_rel_busy", busy0, 0);
    chk("t1_rel_tvalid", bus0.lii_out_p0_tvalid, 0);
    chk("t1_rel_grant", grant0, 0);

    // Two requesters, 4-beat bursts with one idle cycle per switch
    do_reset();
    t2_v = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    t2_s = '{0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
    t2_n = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 4};
    bus0.req_tvalid = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t2_tvalid", bus0.lii_out_p0_tvalid, 64'(t2_v[k]));
      if (t2_v[k] != 0) begin
        chk("t2_src", bus0.lii_out_p0_src, 64'(t2_s[k]));
        chkd("t2_data", bus0.lii_out_p0_tdata, mk(t2_s[k], t2_n[k]));
      end
      if (k == 5) chk("t2_grant_switch", grant0, 2);
    end

    // All four requesters: grant order 0,1,2,3,0
    do_reset();
    bus0.req_tvalid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("t3_grant", grant0, 64'(r % 4));
      chk("t3_busy", busy0, 1);
      repeat (4) tick();
      chk("t3_rel_busy", busy0, 0);
      chk("t3_src", bus0.lii_out_p0_src, 64'(r % 4));
      chkd("t3_data", bus0.lii_out_p0_tdata, mk(r % 4, (r / 4) * 4 + 3));
    end

    // Phy stall for 5 cycles mid-burst on requester 1
    do_reset();
    bus0.req_tvalid = 4'b0010;
    tick();
    chk("t4_grant", grant0, 1);
    tick();
    chkd("t4_b0_data", bus0.lii_out_p0_tdata, mk(1, 0));
    bus0.lii_out_p0_tready = 1'b0;
    #2;
    chk("t4_stall_ready", bus0.req_tready, 0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t4_hold_valid", bus0.lii_out_p0_tvalid, 1);
      chkd("t4_hold_data", bus0.lii_out_p0_tdata, mk(1, 0));
      chk("t4_hold_src", bus0.lii_out_p0_src, 1);
      #2;
      chk("t4_hold_ready", bus0.req_tready, 0);
    end
    bus0.lii_out_p0_tready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      tick();
      chkd("t4_post_data", bus0.lii_out_p0_tdata, mk(1, b));
    end
    chk("t4_burst_end", busy0, 0);
    tick();
    chk("t4_regrant_busy", busy0, 1);
    chk("t4_regrant_idx", grant0, 1);
    chk("t4_regrant_gap", bus0.lii_out_p0_tvalid, 0);

    // Asynchronous reset in the middle of a burst
    do_reset();
    bus0.req_tvalid = 4'b0100;
    tick();
    tick();
    tick();
    chkd("t5_pre_data", bus0.lii_out_p0_tdata, mk(2, 1));
    arstn = 1'b0;
    #1;
    chk("t5_rst_tvalid", bus0.lii_out_p0_tvalid, 0);
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_grant", grant0, 3);
    chk("t5_rst_ready", bus0.req_tready, 0);
    for (int i = 0; i < 4; i++) beat[i] = 0;
    drive_data();
    bus0.req_tvalid = 4'b0101;
    @(negedge aclk);
    arstn = 1'b1;
    @(posedge aclk);
    #1;
    chk("t5_first_grant", grant0, 0);
    tick();
    chk("t5_first_src", bus0.lii_out_p0_src, 0);
    chkd("t5_first_data", bus0.lii_out_p0_tdata, mk(0, 0));

    // BURST=1 with src wrap on the second instance
    bus1.req_tvalid = 4'b0110;
    tick();
    chk("t6_grant_a", grant1, 1);
    tick();
    chk("t6_beat_a_valid", bus1.lii_out_p0_tvalid, 1);
    chk("t6_beat_a_src", bus1.lii_out_p0_src, 8'd255);
    chk("t6_beat_a_dst", bus1.lii_out_p0_dst, 8'hD1);
    chk("t6_beat_a_busy", busy1, 0);
    tick();
    chk("t6_gap_a", bus1.lii_out_p0_tvalid, 0);
    chk("t6_grant_b", grant1, 2);
    tick();
    chk("t6_beat_b_valid", bus1.lii_out_p0_tvalid, 1);
    chk("t6_beat_b_src", bus1.lii_out_p0_src, 8'd0);
    chk("t6_beat_b_dst", bus1.lii_out_p0_dst, 8'hD2);
    tick();
    chk("t6_grant_c", grant1, 1);
    tick();
    chk("t6_beat_c_src", bus1.lii_out_p0_src, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule

// File: doc/lii_out_arbiter.md
Name: lii_out_arbiter

Overview:
- Shares one LII physical output channel between NREQ logical kernel output streams (AXI-Stream style valid/ready).
- Round-robin arbitration with burst-hold: a granted stream keeps the channel for up to BURST beats or until it drops tvalid.
- Tags each beat with per-stream src/dst.
- Sits between kernel wrappers' out_stream side and the phy output; registered output stage gives 1-cycle latency.

Parameters:
- NREQ, 4, number of logical requesters (>=2)
- PW, 1024, packing/data width
- BURST, 4, max beats per grant (>=1)
- SRC_BASE, 0, src tag of requester i = SRC_BASE + i (8-bit, wraps mod 256)

Ports:
- aclk  in  1  clock
- arstn  in  1  async active-low reset
- req_tdata  in  NREQ*PW  requester i data at [i*PW +: PW]
- req_tvalid  in  NREQ  per-requester valid
- req_tready  out  NREQ  per-requester ready
- req_dst  in  NREQ*8  requester i destination at [i*8 +: 8]
- lii_out_p0_tdata  out  PW  phy data
- lii_out_p0_tvalid  out  1  phy valid
- lii_out_p0_tready  in  1  phy ready
- lii_out_p0_src  out  8  source tag of current beat
- lii_out_p0_dst  out  8  destination tag of current beat
- grant_idx  out  clog2(NREQ)  current/last granted requester
- busy  out  1  high in GRANT state

Behaviour:
- Clock and reset: one clock aclk; reset arstn is asynchronous, active-low.
- Reset values:
  - lii_out_p0_tvalid=0; tdata/src/dst=0.
  - req_tready=0; grant_idx=NREQ-1; busy=0.
  - state=IDLE; beat counter=0.
  - Effect: requester 0 has first priority.
- State IDLE:
  - req_tready all 0.
  - If any req_tvalid, select the first set bit scanning cyclically from grant_idx+1 (wrap at NREQ).
  - Register grant_idx, go to GRANT next cycle, clear counter.
  - Else stay in IDLE.
- State GRANT:
  - out_free = !lii_out_p0_tvalid | lii_out_p0_tready.
  - req_tready[grant_idx] = out_free; all other bits 0 (combinational from registers and lii_out_p0_tready).
  - Accept = req_tvalid[g] & req_tready[g]. On accept, next cycle:
    - lii_out_p0_tvalid=1, tdata=req beat.
    - src=SRC_BASE+g, dst=req_dst[g].
    - counter increments.
  - If out_free and no accept, lii_out_p0_tvalid clears to 0.
  - Release to IDLE when:
    - (a) an accept occurs with counter==BURST-1, or
    - (b) req_tvalid[g]==0 in any GRANT cycle.
  - On release the counter clears; grant_idx holds, so the next scan starts after it.
- Output register: while lii_out_p0_tvalid=1 and lii_out_p0_tready=0, data/src/dst/valid are held stable. A requester is never accepted into an occupied register.
- Latency: a beat accepted at cycle t appears on the phy at t+1. Arbitration costs 1 IDLE cycle per grant switch.
- Pending output beat: IDLE does not clear a pending beat; it drains whenever lii_out_p0_tready=1.
- Simultaneous release and new request: the requester just released gets lowest priority. If it is the only valid requester, it is re-granted after one IDLE cycle.
- BURST=1: every accepted beat releases the grant.
- Reset mid-burst: asserting arstn low immediately clears all state; any in-flight output beat is dropped.
- No combinational path from req_tvalid to req_tready.

Test Plan:
- Req 0 only, 3 beats (D0..D2) with valid held, BURST=4, tready=1 -> phy shows D0,D1,D2 on consecutive cycles starting 2 cycles after first valid, src=0, dst=req_dst[0]; grant released when valid drops.
- Reqs 0 and 2 both continuously valid, BURST=4 -> phy beat sequence: 4 from req0, 1 idle cycle, 4 from req2, 1 idle cycle, 4 from req0; src tags 0/2 accordingly.
- All 4 requesters valid -> grant order 0,1,2,3,0; grant_idx matches.
- Req 1 streaming, lii_out_p0_tready low for 5 cycles mid-burst -> output beat held bit-identical, req_tready[1]=0 during the stall, no beats lost or duplicated after release.
- arstn pulsed low during beat 2 of a burst -> tvalid=0, busy=0, grant_idx=NREQ-1 immediately; after release, req0 wins first.
- BURST=1, SRC_BASE=254, reqs 1 and 2 valid -> alternating single beats with src=255, 0 (wrap).
